// File: rtl/scan_chain_driver_pkg.sv
// Shared definitions for the scan-chain driver: chain mode encoding and FSM states.
package scan_chain_driver_pkg;

    localparam logic [1:0] SCAN_FUNC  = 2'b00;
    localparam logic [1:0] SCAN_SHIFT = 2'b01;
    localparam logic [1:0] SCAN_CAPT  = 2'b10;
    localparam logic [1:0] SCAN_HOLD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        REPORT
    } scan_state_t;

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter shared by both shift phases; tc flags the last bit of the chain.
module scan_bit_counter #(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/scan_chain_driver.sv
// Loads a pattern into one scan chain, pulses capture, shifts the response out
// and compares it against the expected vector.
//
//   state     | meaning
//   IDLE      | waiting for start; last result held on pass/captured_out
//   SHIFT_IN  | pattern shifted in MSB first, one bit per cycle
//   CAPTURE   | one cycle of functional capture in the chain
//   SHIFT_OUT | response shifted out via scl, last flip-flop first
//   REPORT    | done pulse; result valid
module scan_chain_driver
    import scan_chain_driver_pkg::*;
#(
    parameter int CHAIN_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expect_in,
    input  logic                 scl,
    output logic                 sci,
    output logic                 se0,
    output logic                 se1,
    output logic                 en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured_out
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    scan_state_t          state;
    logic [1:0]           mode;
    logic [CHAIN_LEN-1:0] pat_reg;
    logic [CHAIN_LEN-1:0] exp_reg;
    logic [CHAIN_LEN-1:0] resp_reg;
    logic [CHAIN_LEN-1:0] resp_next;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 cnt_tc;

    assign {se1, se0} = mode;

    assign cnt_clr = ((state == IDLE) && start) || (state == CAPTURE);
    assign cnt_inc = ((state == SHIFT_IN) || (state == SHIFT_OUT)) && !cnt_tc;

    scan_bit_counter #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    // First scl sample ends up in the MSB after CHAIN_LEN shifts, so resp[k] = flip-flop k.
    always_comb begin
        resp_next    = resp_reg << 1;
        resp_next[0] = scl;
    end

    // Outputs are loaded one edge early so they are valid throughout the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            sci          <= 1'b0;
            mode         <= SCAN_FUNC;
            en           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            captured_out <= '0;
            pat_reg      <= '0;
            exp_reg      <= '0;
            resp_reg     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_reg  <= pattern_in << 1;
                        exp_reg  <= expect_in;
                        resp_reg <= '0;
                        sci      <= pattern_in[CHAIN_LEN-1];
                        mode     <= SCAN_SHIFT;
                        en       <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    if (cnt_tc) begin
                        sci   <= 1'b0;
                        mode  <= SCAN_CAPT;
                        state <= CAPTURE;
                    end else begin
                        sci     <= pat_reg[CHAIN_LEN-1];
                        pat_reg <= pat_reg << 1;
                    end
                end
                CAPTURE: begin
                    mode  <= SCAN_SHIFT;
                    state <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    resp_reg <= resp_next;
                    if (cnt_tc) begin
                        mode         <= SCAN_FUNC;
                        en           <= 1'b0;
                        done         <= 1'b1;
                        captured_out <= resp_next;
                        pass         <= (resp_next == exp_reg);
                        state        <= REPORT;
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver driving a behavioural 3-flop scan chain.
module tb_scan_chain_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] pattern_in = 3'b000;
    logic [2:0] expect_in = 3'b000;
    logic       scl;
    logic       sci, se0, se1, en, busy, done, pass;
    logic [2:0] captured_out;

    int total = 0;
    int bad = 0;

    logic [2:0] ff = 3'b000;
    logic [2:0] d_val = 3'b000;
    logic       cap_hold = 1'b1;

    logic       sci_log  [0:31];
    logic [2:0] cap_log  [0:31];
    logic       pass_log [0:31];
    logic [31:0] done_vec, busy_vec, capt_vec, shift_vec;

    scan_chain_driver #(.CHAIN_LEN(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pattern_in   (pattern_in),
        .expect_in    (expect_in),
        .scl          (scl),
        .sci          (sci),
        .se0          (se0),
        .se1          (se1),
        .en           (en),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .captured_out (captured_out)
    );

    always #5 clk = ~clk;

    // Behavioural chain: flop 0 nearest sci, scl from flop 2.
    assign scl = ff[2];
    always @(posedge clk) begin
        if (en) begin
            case ({se1, se0})
                2'b01: ff <= {ff[1:0], sci};
                2'b10: if (!cap_hold) ff <= d_val;
                default: ;
            endcase
        end
    end

    task automatic launch(input logic [2:0] p, input logic [2:0] e);
        @(negedge clk);
        pattern_in = p;
        expect_in  = e;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Logs outputs at the negedge of cycles 1..n; smask[c] drives start into edge c.
    task automatic run_cycles(input int n, input logic [31:0] smask);
        done_vec = '0; busy_vec = '0; capt_vec = '0; shift_vec = '0;
        for (int c = 1; c <= n; c++) begin
            sci_log[c]   = sci;
            cap_log[c]   = captured_out;
            pass_log[c]  = pass;
            done_vec[c]  = done;
            busy_vec[c]  = busy;
            capt_vec[c]  = en && ({se1, se0} == 2'b10);
            shift_vec[c] = en && ({se1, se0} == 2'b01);
            start = smask[c];
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({sci, se1, se0, en, busy, done, pass, captured_out} !== 10'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {sci, se1, se0, en, busy, done, pass, captured_out});
        end
        @(negedge clk);
        reset = 1'b1;
        run_cycles(3, 32'h0);
        total++;
        if (busy_vec !== 32'h0 || done_vec !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle busy=%h done=%h want=0", busy_vec, done_vec);
        end
    endtask

    task automatic test_loopback();
        cap_hold = 1'b1;
        launch(3'b101, 3'b101);
        run_cycles(10, 32'h0);
        total++;
        if ({sci_log[1], sci_log[2], sci_log[3]} !== 3'b101) begin
            bad++;
            $display("FAIL loop_sci got=%b want=101", {sci_log[1], sci_log[2], sci_log[3]});
        end
        total++;
        if (done_vec !== 32'h100) begin
            bad++;
            $display("FAIL loop_done got=%h want=00000100", done_vec);
        end
        total++;
        if (busy_vec !== 32'h1FE) begin
            bad++;
            $display("FAIL loop_busy got=%h want=000001fe", busy_vec);
        end
        total++;
        if (capt_vec !== 32'h10 || shift_vec !== 32'hEE) begin
            bad++;
            $display("FAIL loop_modes capt=%h shift=%h want=10/ee", capt_vec, shift_vec);
        end
        total++;
        if (cap_log[8] !== 3'b101 || pass_log[8] !== 1'b1) begin
            bad++;
            $display("FAIL loop_result cap=%b pass=%b want=101/1", cap_log[8], pass_log[8]);
        end
    endtask

    task automatic test_capture();
        cap_hold = 1'b0;
        d_val    = 3'b111;
        launch(3'b010, 3'b111);
        run_cycles(10, 32'h0);
        total++;
        if (capt_vec !== 32'h10) begin
            bad++;
            $display("FAIL capt_once got=%h want=00000010", capt_vec);
        end
        total++;
        if (cap_log[8] !== 3'b111 || pass_log[8] !== 1'b1) begin
            bad++;
            $display("FAIL capt_result cap=%b pass=%b want=111/1", cap_log[8], pass_log[8]);
        end
    endtask

    task automatic test_mismatch();
        cap_hold = 1'b0;
        d_val    = 3'b000;
        launch(3'b110, 3'b001);
        run_cycles(10, 32'h0);
        total++;
        if (cap_log[8] !== 3'b000 || pass_log[8] !== 1'b0) begin
            bad++;
            $display("FAIL mism_result cap=%b pass=%b want=000/0", cap_log[8], pass_log[8]);
        end
        total++;
        if (done_vec !== 32'h100) begin
            bad++;
            $display("FAIL mism_done got=%h want=00000100", done_vec);
        end
    endtask

    task automatic test_start_while_busy();
        cap_hold = 1'b1;
        launch(3'b101, 3'b101);
        run_cycles(12, 32'h104);
        total++;
        if (busy_vec !== 32'h1FE || done_vec !== 32'h100) begin
            bad++;
            $display("FAIL stray_start busy=%h done=%h want=1fe/100", busy_vec, done_vec);
        end
        total++;
        if (cap_log[12] !== 3'b101 || pass_log[12] !== 1'b1) begin
            bad++;
            $display("FAIL stray_result cap=%b pass=%b want=101/1", cap_log[12], pass_log[12]);
        end
    endtask

    task automatic test_reset_mid_run();
        cap_hold = 1'b1;
        launch(3'b011, 3'b011);
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b1 || {se1, se0} !== 2'b01) begin
            bad++;
            $display("FAIL midrst_pre busy=%b mode=%b want=1/01", busy, {se1, se0});
        end
        reset = 1'b0;
        #1;
        total++;
        if ({sci, se1, se0, en, busy, done, pass, captured_out} !== 10'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b want=0", {sci, se1, se0, en, busy, done, pass, captured_out});
        end
        @(negedge clk);
        reset = 1'b1;
        run_cycles(10, 32'h0);
        total++;
        if (done_vec !== 32'h0 || busy_vec !== 32'h0) begin
            bad++;
            $display("FAIL midrst_partial done=%h busy=%h want=0", done_vec, busy_vec);
        end
        launch(3'b110, 3'b110);
        run_cycles(10, 32'h0);
        total++;
        if (done_vec !== 32'h100 || cap_log[8] !== 3'b110 || pass_log[8] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_rerun done=%h cap=%b pass=%b want=100/110/1", done_vec, cap_log[8], pass_log[8]);
        end
    endtask

    task automatic test_back_to_back();
        cap_hold = 1'b1;
        launch(3'b101, 3'b101);
        pattern_in = 3'b011;
        expect_in  = 3'b011;
        run_cycles(20, 32'h200);
        total++;
        if (done_vec !== 32'h20100) begin
            bad++;
            $display("FAIL b2b_done got=%h want=00020100", done_vec);
        end
        total++;
        if (busy_vec !== 32'h3FDFE) begin
            bad++;
            $display("FAIL b2b_busy got=%h want=0003fdfe", busy_vec);
        end
        total++;
        if ({sci_log[10], sci_log[11], sci_log[12]} !== 3'b011) begin
            bad++;
            $display("FAIL b2b_sci got=%b want=011", {sci_log[10], sci_log[11], sci_log[12]});
        end
        total++;
        if (cap_log[9] !== 3'b101 || cap_log[17] !== 3'b011 || pass_log[17] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_result first=%b second=%b pass=%b want=101/011/1", cap_log[9], cap_log[17], pass_log[17]);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_capture();
        test_mismatch();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
